compression_element_arbiter: RTL and testbench

Arbiter and sequencer that shares one compression element between `NUM_STREAM_ELEMENTS` stream elements inside the AXI stream compressor. Each stream element raises a request once it holds a complete delimited element (variable field, 0x2C delimiter, fixed field). The arbiter picks one requester and streams its bytes to the compressor in `DATA_BUS_WIDTH_BYTES` beats under a ready handshake. When the element is finished it releases the requester.

---
 rtl/compression_element_arbiter.sv | 177 +++++++++++++++++
 tb/tb_compression_element_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compression_element_arbiter.sv
// Shares one compression element among NUM_STREAM_ELEMENTS requesters, streaming the granted
// element in bus-width beats. Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).

module compression_element_lane_mask #(
   parameter int LANE  = 0,
   parameter int REM_W = 3
) (
   input  logic [REM_W-1:0] lenRem,
   output logic             laneValid
);
   localparam logic [REM_W-1:0] LANE_IDX = REM_W'(LANE);

   // a zero remainder means the final beat is full
   assign laneValid = (lenRem == '0) || (LANE_IDX < lenRem);
endmodule

module compression_element_arbiter #(
   parameter int DATA_BUS_WIDTH_BYTES     = 8,
   parameter int NUM_STREAM_ELEMENTS      = 4,
   parameter int MAX_STREAMELEMENT_LENGTH = 34,
   parameter int LEN_W                    = $clog2(MAX_STREAMELEMENT_LENGTH + 1)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic [NUM_STREAM_ELEMENTS-1:0]            elementReq,
   input  logic [NUM_STREAM_ELEMENTS-1:0][LEN_W-1:0] elementLength,
   input  logic                                      compressorReady,
   output logic [NUM_STREAM_ELEMENTS-1:0]            elementGrant,
   output logic                                      beatValid,
   output logic                                      elementAdvance,
   output logic                                      compressorStart,
   output logic                                      compressorLast,
   output logic [DATA_BUS_WIDTH_BYTES-1:0]           compressorByteValid,
   output logic [NUM_STREAM_ELEMENTS-1:0]            elementDone,
   output logic                                      lengthError,
   output logic                                      busy
);
   localparam int W         = DATA_BUS_WIDTH_BYTES;
   localparam int N         = NUM_STREAM_ELEMENTS;
   localparam int MAX_BEATS = (MAX_STREAMELEMENT_LENGTH + W - 1) / W;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);
   localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;
   localparam int REM_W     = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             legal;
      logic [CNT_W-1:0] beats;
      logic [REM_W-1:0] rem;
   } arbPick_t;

   state_t           state;
   arbPick_t         pick;
   logic [N-1:0]     pickOneHot;
   logic [W-1:0]     pickLastMask;
   logic [W-1:0]     lastMaskQ;
   logic [CNT_W-1:0] beatCnt;
`ifdef ARBITER_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rrPtr;
   logic [IDX_W-1:0] winIdxQ;
`endif

   always_comb begin
      int lenI;
`ifdef ARBITER_ROUND_ROBIN_EN
      int   cand;
      logic found;
      cand  = 0;
      found = 1'b0;
`endif
      pick = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      // first requester at or after the pointer, wrapping upward
      for (int k = 0; k < N; k++) begin
         cand = (int'(rrPtr) + k) % N;
         if (!found && elementReq[cand]) begin
            found    = 1'b1;
            pick.idx = IDX_W'(cand);
         end
      end
`else
      for (int k = N - 1; k >= 0; k--)
         if (elementReq[k]) pick.idx = IDX_W'(k);
`endif
      lenI       = int'(elementLength[pick.idx]);
      pick.legal = (lenI >= 1) && (lenI <= MAX_STREAMELEMENT_LENGTH);
      pick.beats = CNT_W'((lenI + W - 1) / W);
      pick.rem   = REM_W'(lenI % W);
      pickOneHot = '0;
      pickOneHot[pick.idx] = 1'b1;
   end

   for (genvar g = 0; g < W; g++) begin : gLane
      compression_element_lane_mask #(.LANE(g), .REM_W(REM_W)) uLane (
         .lenRem   (pick.rem),
         .laneValid(pickLastMask[g])
      );
   end

   assign elementAdvance = beatValid & compressorReady;

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         beatCnt             <= '0;
         lastMaskQ           <= '0;
         elementGrant        <= '0;
         beatValid           <= 1'b0;
         compressorStart     <= 1'b0;
         compressorLast      <= 1'b0;
         compressorByteValid <= '0;
         elementDone         <= '0;
         lengthError         <= 1'b0;
         busy                <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
         rrPtr               <= '0;
         winIdxQ             <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|elementReq) begin
                  busy <= 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
                  winIdxQ <= pick.idx;
`endif
                  if (pick.legal) begin
                     state               <= XFER;
                     beatCnt             <= pick.beats;
                     lastMaskQ           <= pickLastMask;
                     elementGrant        <= pickOneHot;
                     beatValid           <= 1'b1;
                     compressorStart     <= 1'b1;
                     compressorLast      <= (pick.beats == CNT_W'(1));
                     compressorByteValid <= (pick.beats == CNT_W'(1)) ? pickLastMask : '1;
                  end else begin
                     // rejected element: this pulse cycle doubles as the DONE cycle
                     state       <= DONE;
                     lengthError <= 1'b1;
                     elementDone <= pickOneHot;
                  end
               end
            end
            XFER: begin
               if (compressorReady) begin
                  if (beatCnt == CNT_W'(1)) begin
                     state               <= DONE;
                     elementDone         <= elementGrant;
                     elementGrant        <= '0;
                     beatValid           <= 1'b0;
                     compressorStart     <= 1'b0;
                     compressorLast      <= 1'b0;
                     compressorByteValid <= '0;
                  end else begin
                     beatCnt             <= beatCnt - CNT_W'(1);
                     compressorStart     <= 1'b0;
                     compressorLast      <= (beatCnt == CNT_W'(2));
                     compressorByteValid <= (beatCnt == CNT_W'(2)) ? lastMaskQ : '1;
                  end
               end
            end
            DONE: begin
               state       <= IDLE;
               busy        <= 1'b0;
               elementDone <= '0;
               lengthError <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
               rrPtr <= (winIdxQ == IDX_W'(N - 1)) ? '0 : winIdxQ + IDX_W'(1);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_compression_element_arbiter.sv
// Randomized bench for compression_element_arbiter: requesters and an element-level reference
// model live here; each cycle's outputs are compared against the model's expectation.

module tb_compression_element_arbiter;
   localparam int W      = 8;
   localparam int N      = 4;
   localparam int MAXL   = 34;
   localparam int LEN_W  = $clog2(MAXL + 1);
   localparam int M_IDLE = 0;
   localparam int M_XFER = 1;
   localparam int M_DONE = 2;

   logic                      clk;
   logic                      reset;
   logic                      compressorReady;
   logic [N-1:0]              elementReq;
   logic [N-1:0][LEN_W-1:0]   elementLength;
   logic [N-1:0]              elementGrant;
   logic [N-1:0]              elementDone;
   logic                      beatValid;
   logic                      elementAdvance;
   logic                      compressorStart;
   logic                      compressorLast;
   logic                      lengthError;
   logic                      busy;
   logic [W-1:0]              compressorByteValid;

   compression_element_arbiter #(
      .DATA_BUS_WIDTH_BYTES(W),
      .NUM_STREAM_ELEMENTS(N),
      .MAX_STREAMELEMENT_LENGTH(MAXL),
      .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .elementReq(elementReq),
      .elementLength(elementLength),
      .compressorReady(compressorReady),
      .elementGrant(elementGrant),
      .beatValid(beatValid),
      .elementAdvance(elementAdvance),
      .compressorStart(compressorStart),
      .compressorLast(compressorLast),
      .compressorByteValid(compressorByteValid),
      .elementDone(elementDone),
      .lengthError(lengthError),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // requesters
   bit pend[N];
   int plen[N];
   bit rearm[N];

   // element-level reference model
   int mode = M_IDLE;
   int cur = 0, beat = 0, nb = 0, curLen = 0, ptr = 0;
   bit err = 1'b0;

   int winners[$];
   int readyQ[$];
   int advCount = 0, errCount = 0;
   logic [W-1:0] lastMaskSeen;

   int readyPct = 100, raisePct = 0, illegalPct = 0, fixedLen = 0;
   bit autoRearm = 1'b0;
   logic [N-1:0] raiseMask = '0;

   function automatic int ceilBeats(input int len);
      return (len + W - 1) / W;
   endfunction

   function automatic logic [W-1:0] lastMaskOf(input int len);
      int r;
      r = len % W;
      return (r == 0) ? {W{1'b1}} : W'((1 << r) - 1);
   endfunction

   function automatic int newLen();
      if (fixedLen > 0) return fixedLen;
      if (int'($urandom_range(99)) < illegalPct)
         return ($urandom_range(1) == 0) ? 0 : int'($urandom_range(63, MAXL + 1));
      return int'($urandom_range(MAXL, 1));
   endfunction

   function automatic int pickWinner();
`ifdef ARBITER_ROUND_ROBIN_EN
      for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
`else
      for (int i = 0; i < N; i++) if (pend[i]) return i;
`endif
      return -1;
   endfunction

   task automatic drive_inputs();
      int r;
      for (int i = 0; i < N; i++) begin
         elementReq[i]    = pend[i];
         elementLength[i] = pend[i] ? LEN_W'(plen[i]) : LEN_W'($urandom);
      end
      if (readyQ.size() > 0) begin
         r = readyQ.pop_front();
         compressorReady = (r != 0);
      end else begin
         compressorReady = (int'($urandom_range(99)) < readyPct);
      end
   endtask

   task automatic cfg(input int rdy, input int raise, input int illegal,
                      input logic [N-1:0] msk, input bit rearmEn, input int flen);
      readyPct = rdy; raisePct = raise; illegalPct = illegal;
      raiseMask = msk; autoRearm = rearmEn; fixedLen = flen;
      winners.delete(); readyQ.delete();
      advCount = 0; errCount = 0; lastMaskSeen = '0;
   endtask

   // leaves time at 1 unit after a clock edge with reset released and everything idle
   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; rearm[i] = 1'b0; end
      readyQ.delete();
      drive_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      mode = M_IDLE; ptr = 0; err = 1'b0;
   endtask

   task automatic run_traffic(input int cycles);
      logic [N-1:0] eG, eD;
      logic [W-1:0] eM;
      logic eV, eA, eS, eL, eE, eB;
      int w;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && raiseMask[i] &&
                ((rearm[i] && autoRearm) || int'($urandom_range(99)) < raisePct)) begin
               pend[i] = 1'b1;
               plen[i] = newLen();
            end
            rearm[i] = 1'b0;
         end
         drive_inputs();
         @(negedge clk);

         eG = '0; eD = '0; eM = '0;
         eV = 1'b0; eA = 1'b0; eS = 1'b0; eL = 1'b0; eE = 1'b0; eB = 1'b0;
         if (mode == M_XFER) begin
            eG[cur] = 1'b1; eV = 1'b1; eA = compressorReady; eB = 1'b1;
            eS = (beat == 0);
            eL = (beat == nb - 1);
            eM = eL ? lastMaskOf(curLen) : {W{1'b1}};
         end else if (mode == M_DONE) begin
            eD[cur] = 1'b1; eE = err; eB = 1'b1;
         end
         checks++;
         if ({elementGrant, elementDone} !== {eG, eD}) begin
            errors++;
            $display("FAIL grant_done t=%0t: got grant=%b done=%b want grant=%b done=%b",
                     $time, elementGrant, elementDone, eG, eD);
         end
         checks++;
         if ({beatValid, elementAdvance, compressorStart, compressorLast, lengthError, busy} !==
             {eV, eA, eS, eL, eE, eB}) begin
            errors++;
            $display("FAIL ctrl t=%0t: got vld/adv/start/last/lerr/busy=%b want %b", $time,
                     {beatValid, elementAdvance, compressorStart, compressorLast, lengthError, busy},
                     {eV, eA, eS, eL, eE, eB});
         end
         checks++;
         if (compressorByteValid !== eM) begin
            errors++;
            $display("FAIL byte_mask t=%0t: got %h want %h", $time, compressorByteValid, eM);
         end
         if (elementAdvance === 1'b1) advCount++;
         if (lengthError === 1'b1) errCount++;
         if (beatValid === 1'b1 && compressorLast === 1'b1) lastMaskSeen = compressorByteValid;

         case (mode)
            M_IDLE: begin
               w = pickWinner();
               if (w >= 0) begin
                  cur = w; curLen = plen[w];
                  winners.push_back(w);
                  if (curLen >= 1 && curLen <= MAXL) begin
                     mode = M_XFER; beat = 0; nb = ceilBeats(curLen);
                  end else begin
                     mode = M_DONE; err = 1'b1;
                  end
               end
            end
            M_XFER: begin
               if (compressorReady) begin
                  if (beat == nb - 1) begin mode = M_DONE; err = 1'b0; end
                  else beat++;
               end
            end
            default: begin
               pend[cur] = 1'b0; rearm[cur] = 1'b1;
               ptr = (cur + 1) % N;
               mode = M_IDLE;
            end
         endcase
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({elementGrant, elementDone, beatValid, elementAdvance, compressorStart, compressorLast,
           compressorByteValid, lengthError, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got grant=%b done=%b vld=%b mask=%h busy=%b want all 0",
                  elementGrant, elementDone, beatValid, compressorByteValid, busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      do_reset();
      cfg(100, 0, 0, '0, 1'b0, 0);
      pend[1] = 1'b1; plen[1] = 27;
      run_traffic(10);
      checks++;
      if (advCount != 4) begin errors++; $display("FAIL single_beats: got %0d want 4", advCount); end
      checks++;
      if (lastMaskSeen !== 8'h07) begin
         errors++; $display("FAIL single_last_mask: got %h want 07", lastMaskSeen);
      end
      checks++;
      if (winners.size() != 1 || winners[0] != 1) begin
         errors++; $display("FAIL single_winner: got %0d grants want one grant to 1", winners.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cfg(100, 0, 0, '0, 1'b0, 0);
      readyQ = '{1, 1, 0, 0, 1, 1};
      pend[2] = 1'b1; plen[2] = 21;
      run_traffic(12);
      checks++;
      if (advCount != 3) begin errors++; $display("FAIL bp_advance: got %0d want 3", advCount); end
      checks++;
      if (lastMaskSeen !== 8'h1F) begin
         errors++; $display("FAIL bp_last_mask: got %h want 1f", lastMaskSeen);
      end
   endtask

   task automatic test_exact_multiple();
      do_reset();
      cfg(100, 0, 0, '0, 1'b0, 0);
      pend[0] = 1'b1; plen[0] = 24;
      run_traffic(8);
      checks++;
      if (advCount != 3) begin errors++; $display("FAIL exact_beats: got %0d want 3", advCount); end
      checks++;
      if (lastMaskSeen !== 8'hFF) begin
         errors++; $display("FAIL exact_last_mask: got %h want ff", lastMaskSeen);
      end
   endtask

   task automatic test_illegal_length();
      do_reset();
      cfg(100, 0, 0, '0, 1'b0, 0);
      pend[3] = 1'b1; plen[3] = 0;
      run_traffic(4);
      pend[3] = 1'b1; plen[3] = MAXL + 1;
      run_traffic(4);
      checks++;
      if (errCount != 2) begin errors++; $display("FAIL illegal_pulses: got %0d want 2", errCount); end
      checks++;
      if (advCount != 0) begin errors++; $display("FAIL illegal_beats: got %0d want 0", advCount); end
   endtask

   task automatic test_contention();
      int expOrder[4];
`ifdef ARBITER_ROUND_ROBIN_EN
      expOrder = '{0, 2, 0, 2};
`else
      expOrder = '{0, 0, 0, 0};
`endif
      do_reset();
      cfg(100, 0, 0, 4'b0101, 1'b1, 0);
      pend[0] = 1'b1; plen[0] = newLen();
      pend[2] = 1'b1; plen[2] = newLen();
      run_traffic(40);
      checks++;
      if (winners.size() < 4) begin
         errors++; $display("FAIL contention_count: got %0d grants want >= 4", winners.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (winners[i] != expOrder[i]) begin
               errors++;
               $display("FAIL contention_order[%0d]: got %0d want %0d", i, winners[i], expOrder[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      cfg(70, 20, 10, '1, 1'b0, 0);
      run_traffic(600);
      checks++;
      if (winners.size() < 20) begin
         errors++; $display("FAIL random_progress: got %0d grants want >= 20", winners.size());
      end
   endtask

   task automatic test_reset_mid_xfer();
      do_reset();
      cfg(100, 0, 0, '0, 1'b0, 0);
      pend[1] = 1'b1; plen[1] = 8;
      run_traffic(5);
      pend[2] = 1'b1; plen[2] = MAXL;
      run_traffic(3);
      do_reset();
      @(negedge clk);
      checks++;
      if ({elementGrant, elementDone, beatValid, elementAdvance, compressorStart, compressorLast,
           compressorByteValid, lengthError, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got grant=%b done=%b vld=%b mask=%h busy=%b want all 0",
                  elementGrant, elementDone, beatValid, compressorByteValid, busy);
      end
      @(posedge clk); #1;
      cfg(100, 0, 0, '0, 1'b0, 0);
      pend[0] = 1'b1; plen[0] = 8;
      pend[3] = 1'b1; plen[3] = 8;
      run_traffic(6);
      checks++;
      if (winners.size() < 1 || winners[0] != 0) begin
         errors++; $display("FAIL midreset_pointer: got first winner %0d want 0",
                            (winners.size() > 0) ? winners[0] : -1);
      end
   endtask

   initial begin
      reset = 1'b1;
      compressorReady = 1'b0;
      elementReq = '0;
      elementLength = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_exact_multiple();
      test_illegal_length();
      test_contention();
      test_random();
      test_reset_mid_xfer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
